// File: rtl/data_cache_data_array_if.sv
// Bus bundle for the data cache data array: CPU port, refill stream and status.
// Master side is the cache controller / memory interface, slave side is the array.
interface data_cache_data_array_if #(
  parameter int SET_ADDR_WIDTH    = 6,
  parameter int WORD_OFFSET_WIDTH = 2,
  parameter int BYTES_PER_WORD    = 4
);
  localparam int W  = 8 * BYTES_PER_WORD;
  localparam int AW = SET_ADDR_WIDTH + WORD_OFFSET_WIDTH;

  logic [AW-1:0]             cpu_addr_i;
  logic                      cpu_re_i;
  logic                      cpu_we_i;
  logic [BYTES_PER_WORD-1:0] cpu_be_i;
  logic [W-1:0]              cpu_wdata_i;
  logic [W-1:0]              cpu_rdata_o;
  logic                      cpu_rvalid_o;
  logic                      cpu_line_valid_o;
  logic                      invalidate_all_i;
  logic                      refill_start_i;
  logic [SET_ADDR_WIDTH-1:0] refill_set_i;
  logic [W-1:0]              refill_data_i;
  logic                      refill_valid_i;
  logic                      refill_ready_o;
  logic                      refill_done_o;
  logic                      busy_o;

  modport master (
    output cpu_addr_i, cpu_re_i, cpu_we_i, cpu_be_i, cpu_wdata_i,
           invalidate_all_i, refill_start_i, refill_set_i, refill_data_i, refill_valid_i,
    input  cpu_rdata_o, cpu_rvalid_o, cpu_line_valid_o, refill_ready_o, refill_done_o, busy_o
  );

  modport slave (
    input  cpu_addr_i, cpu_re_i, cpu_we_i, cpu_be_i, cpu_wdata_i,
           invalidate_all_i, refill_start_i, refill_set_i, refill_data_i, refill_valid_i,
    output cpu_rdata_o, cpu_rvalid_o, cpu_line_valid_o, refill_ready_o, refill_done_o, busy_o
  );
endinterface

// File: rtl/data_cache_data_array.sv
// Data cache data store: byte-enabled CPU port, streamed line refill, per-line valid bits.
// Optional DCACHE_WRITE_BYPASS_EN: same-cycle read+write returns the merged word.
//
// state | meaning
// IDLE  | CPU accesses serviced, waiting for refill_start_i
// FILL  | accepting refill words for the latched set
// DONE  | line complete, valid bit set, refill_done_o pulses
module data_cache_data_array #(
  parameter int SET_ADDR_WIDTH    = 6,
  parameter int WORD_OFFSET_WIDTH = 2,
  parameter int BYTES_PER_WORD    = 4
) (
  input logic                    clk_i,
  input logic                    rst_i,
  data_cache_data_array_if.slave bus
);
  localparam int W         = 8 * BYTES_PER_WORD;
  localparam int AW        = SET_ADDR_WIDTH + WORD_OFFSET_WIDTH;
  localparam int NUM_SETS  = 1 << SET_ADDR_WIDTH;
  localparam int NUM_WORDS = 1 << AW;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

  state_t                       state_q, state_d;
  logic [WORD_OFFSET_WIDTH-1:0] cnt_q;
  logic [SET_ADDR_WIDTH-1:0]    set_q;
  logic [NUM_SETS-1:0]          valid_q;
  logic [W-1:0]                 mem [NUM_WORDS];
  logic [W-1:0]                 rdata_q;
  logic                         rvalid_q;
  logic                         line_valid_q;

  logic                      is_idle, is_fill, is_done;
  logic                      cpu_rd, cpu_wr, fill_beat, last_beat, start;
  logic [AW-1:0]             wr_addr;
  logic [BYTES_PER_WORD-1:0] wr_be;
  logic [W-1:0]              wr_data;
  logic [W-1:0]              rd_word;

  always_comb begin
    is_idle   = (state_q == ST_IDLE);
    is_fill   = (state_q == ST_FILL);
    is_done   = (state_q == ST_DONE);
    cpu_rd    = is_idle & bus.cpu_re_i;
    cpu_wr    = is_idle & bus.cpu_we_i;
    start     = is_idle & bus.refill_start_i;
    fill_beat = is_fill & bus.refill_valid_i;
    last_beat = fill_beat & (cnt_q == '1);
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.refill_start_i) state_d = ST_FILL;
      ST_FILL: if (last_beat)          state_d = ST_DONE;
      ST_DONE:                         state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    bus.refill_ready_o = 1'b0;
    bus.refill_done_o  = 1'b0;
    bus.busy_o         = 1'b0;
    case (state_q)
      ST_FILL: begin
        bus.refill_ready_o = 1'b1;
        bus.busy_o         = 1'b1;
      end
      ST_DONE: begin
        bus.refill_done_o = 1'b1;
        bus.busy_o        = 1'b1;
      end
      default: ;
    endcase
  end

  // Invalidate-all has priority so a line finishing in DONE still ends invalid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      set_q   <= '0;
      valid_q <= '0;
    end else begin
      if (start) begin
        set_q <= bus.refill_set_i;
        cnt_q <= '0;
      end else if (fill_beat) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (bus.invalidate_all_i)  valid_q <= '0;
      else if (start)            valid_q[bus.refill_set_i] <= 1'b0;
      else if (is_done)          valid_q[set_q] <= 1'b1;
    end
  end

  // CPU writes and refill beats never coincide since they live in different states.
  always_comb begin
    wr_addr = bus.cpu_addr_i;
    wr_be   = '0;
    wr_data = bus.cpu_wdata_i;
    if (fill_beat) begin
      wr_addr = {set_q, cnt_q};
      wr_be   = '1;
      wr_data = bus.refill_data_i;
    end else if (cpu_wr) begin
      wr_be = bus.cpu_be_i;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < BYTES_PER_WORD; k++)
      if (wr_be[k]) mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
  end

`ifdef DCACHE_WRITE_BYPASS_EN
  always_comb begin
    rd_word = mem[bus.cpu_addr_i];
    if (cpu_wr)
      for (int k = 0; k < BYTES_PER_WORD; k++)
        if (bus.cpu_be_i[k]) rd_word[8*k +: 8] = bus.cpu_wdata_i[8*k +: 8];
  end
`else
  assign rd_word = mem[bus.cpu_addr_i];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      line_valid_q <= 1'b0;
    end else begin
      rvalid_q <= cpu_rd;
      if (cpu_rd) begin
        rdata_q      <= rd_word;
        line_valid_q <= valid_q[bus.cpu_addr_i[AW-1:WORD_OFFSET_WIDTH]];
      end
    end
  end

  assign bus.cpu_rdata_o      = rdata_q;
  assign bus.cpu_rvalid_o     = rvalid_q;
  assign bus.cpu_line_valid_o = line_valid_q;
endmodule
